// File: rtl/fifo_rv_pkg.sv
`default_nettype none
// ============================================================================
// fifo_rv_pkg : occupancy-width and circular-pointer helpers for fifo_rv
// Rev 1.0
// ============================================================================
package fifo_rv_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps at depth-1 explicitly so non-power-of-two depths work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rv_mem.sv
`default_nettype none
// ============================================================================
// fifo_rv_mem : WIDTH x DEPTH storage, one synchronous write, one async read
// Rev 1.0
// ============================================================================
module fifo_rv_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fifo_rv.sv
`default_nettype none
// ============================================================================
// fifo_rv : single-clock FWFT FIFO, ready/valid, any depth, watermarks.
//           Optional sticky overflow/underflow flags via FIFO_RV_ERR_EN.
// Rev 1.0
// ============================================================================
module fifo_rv
  import fifo_rv_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 7,
  parameter int AF_LEVEL = 5,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      setData_i,
  output logic                      ready_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      getData_i,
  output logic [cnt_w(DEPTH)-1:0]   size_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
`ifdef FIFO_RV_ERR_EN
  output logic                      overflow_o,
  output logic                      underflow_o,
`endif
  output logic                      almost_empty_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] size_q, size_d;
  logic          push, pop;

  assign full_o         = (size_q == CW'(DEPTH));
  assign empty_o        = (size_q == '0);
  assign almost_full_o  = (size_q >= CW'(AF_LEVEL));
  assign almost_empty_o = (size_q <= CW'(AE_LEVEL));
  assign ready_o        = ~full_o;
  assign valid_o        = ~empty_o;
  assign size_o         = size_q;

  // Gating with flags (not with the other request) keeps push&pop legal at any level.
  assign push = setData_i & ready_o & ~flush_i;
  assign pop  = getData_i & valid_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      size_d   = '0;
    end else begin
      if (push) wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
      if (push && !pop)      size_d = size_q + CW'(1);
      else if (pop && !push) size_d = size_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
    end
  end

`ifdef FIFO_RV_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (setData_i && full_o)   overflow_q  <= 1'b1;
      if (getData_i && empty_o)  underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

  fifo_rv_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push & ~rst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rv.sv
`default_nettype none
// ============================================================================
// tb_fifo_rv : directed and random stimulus against a queue reference model
// Rev 1.0
// ============================================================================
module tb_fifo_rv;

  localparam int WIDTH = 8;
  localparam int DEPTH = 7;
  localparam int AF    = 5;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             setData_i = 1'b0;
  logic             getData_i = 1'b0;
  logic             ready_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [WIDTH-1:0] data_o;
  logic [2:0]       size_o;
`ifdef FIFO_RV_ERR_EN
  logic             overflow_o, underflow_o;
  bit               m_ovf, m_unf;
`endif

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] model[$];

  always #5 clk = ~clk;

  fifo_rv #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .data_i         (data_i),
    .setData_i      (setData_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .getData_i      (getData_i),
    .size_o         (size_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
`ifdef FIFO_RV_ERR_EN
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
`endif
    .almost_empty_o (almost_empty_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = model.size();
    chk("size",   32'(size_o),         32'(n));
    chk("valid",  32'(valid_o),        32'(n > 0));
    chk("ready",  32'(ready_o),        32'(n < DEPTH));
    chk("full",   32'(full_o),         32'(n == DEPTH));
    chk("empty",  32'(empty_o),        32'(n == 0));
    chk("afull",  32'(almost_full_o),  32'(n >= AF));
    chk("aempty", 32'(almost_empty_o), 32'(n <= AE));
    if (n > 0) chk("data", 32'(data_o), 32'(model[0]));
`ifdef FIFO_RV_ERR_EN
    chk("ovf", 32'(overflow_o),  32'(m_ovf));
    chk("unf", 32'(underflow_o), 32'(m_unf));
`endif
  endtask

  // Drives one cycle from a negedge, checks the pre-edge state, then advances the model.
  task automatic step(input bit s, input logic [WIDTH-1:0] d, input bit g, input bit f);
    int n;
    setData_i = s; data_i = d; getData_i = g; flush_i = f;
    #1;
    check_all();
    @(posedge clk);
    n = model.size();
    if (f) begin
      model.delete();
`ifdef FIFO_RV_ERR_EN
      m_ovf = 0; m_unf = 0;
`endif
    end else begin
`ifdef FIFO_RV_ERR_EN
      if (s && n == DEPTH) m_ovf = 1;
      if (g && n == 0)     m_unf = 1;
`endif
      if (g && n > 0)     void'(model.pop_front());
      if (s && n < DEPTH) model.push_back(d);
    end
    @(negedge clk);
    setData_i = 0; getData_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model.delete();
`ifdef FIFO_RV_ERR_EN
    m_ovf = 0; m_unf = 0;
`endif
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();
    check_all();

    // 1: three pushes then drain
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0);
    #1;
    chk("t1_size", 32'(size_o), 32'd3);
    chk("t1_head", 32'(data_o), 32'h11);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    #1;
    chk("t1_empty", 32'(empty_o), 32'd1);

    // 2: overfill, extra word dropped
    for (int i = 0; i < 8; i++) step(1, 8'(8'hA0 + i), 0, 0);
    #1;
    chk("t2_full", 32'(full_o), 32'd1);
    chk("t2_size", 32'(size_o), 32'd7);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t2_drain", 32'(data_o), 32'(8'hA0 + i));
      step(0, 8'h00, 1, 0);
    end

    // 3: level 3, simultaneous push/pop across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1, 0);
    #1;
    chk("t3_size", 32'(size_o), 32'd3);
    while (model.size() > 0) step(0, 8'h00, 1, 0);

    // 4: push with pop request on empty
    step(1, 8'h5A, 1, 0);
    #1;
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_data",  32'(data_o),  32'h5A);
    chk("t4_size",  32'(size_o),  32'd1);

    // 5: push+pop while full
    while (model.size() < DEPTH) step(1, 8'(model.size()), 0, 0);
    step(1, 8'hEE, 1, 0);
    #1;
    chk("t5_size",  32'(size_o),  32'd6);
    chk("t5_ready", 32'(ready_o), 32'd1);
    chk("t5_af",    32'(almost_full_o), 32'd1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    #1;
    chk("t5_af_low", 32'(almost_full_o), 32'd0);

    // 6: flush with concurrent push
    while (model.size() > 4) step(0, 8'h00, 1, 0);
    step(1, 8'h77, 0, 1);
    #1;
    chk("t6_size", 32'(size_o), 32'd0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 55), 8'($urandom), bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 99) < 3));
    end
    do_reset();
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
